// File: rtl/refresh_ctrl.sv
// Auto-refresh timing controller: interval counter, postponed-refresh backlog and scheduler handshake.
// Define REFRESH_CTRL_POSTPONE_EN to allow up to MAXPEND postponed refreshes; otherwise the backlog depth is one.
module refresh_ctrl #(
   parameter int unsigned TREFI   = 780,
   parameter int unsigned TRFC    = 8,
   parameter int unsigned MAXPEND = 8
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       enable_i,
   output logic       rfc_req_o,
   input  logic       rfc_ack_i,
   output logic       rfc_end_o,
   output logic       ref_cmd_o,
   output logic       rfc_urgent_o,
   output logic [3:0] pend_o,
   output logic       busy_o,
   output logic       err_o
);

   localparam int unsigned CNT_W = $clog2(TREFI);
   localparam int unsigned RFC_W = $clog2(TRFC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TREFI - 1);
   localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(TRFC - 1);
`ifdef REFRESH_CTRL_POSTPONE_EN
   localparam logic [3:0] PEND_MAX = 4'(MAXPEND);
`else
   // MAXPEND is always >= 1, so this collapses the backlog to a single slot
   localparam logic [3:0] PEND_MAX = 4'(MAXPEND > 0);
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REF  = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RFC_W-1:0] rfc_q, rfc_d;
   logic [3:0]       pend_q, pend_d;
   logic             err_q, err_d;
   logic             req_q, req_d;
   logic             ref_q, ref_d;
   logic             end_q, end_d;
   logic             busy_q, busy_d;
   logic             urgent_q, urgent_d;
   logic             tick;
   logic             issue;

   // Refresh interval counter; held at reload while disabled
   always_comb begin
      tick  = 1'b0;
      cnt_d = CNT_LOAD;
      if (enable_i) begin
         if (cnt_q == '0) begin
            tick = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   assign issue = (state_q == ST_REF);

   // Backlog: a tick and an issue in the same cycle cancel out
   always_comb begin
      pend_d = pend_q;
      err_d  = err_q;
      if (tick && !issue) begin
         if (pend_q == PEND_MAX) begin
            err_d = 1'b1;
         end else begin
            pend_d = pend_q + 4'd1;
         end
      end else if (issue && !tick) begin
         pend_d = pend_q - 4'd1;
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      rfc_d   = rfc_q;
      end_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pend_q != 4'd0) state_d = ST_REQ;
         end
         ST_REQ: begin
            if (rfc_ack_i) state_d = ST_REF;
         end
         ST_REF: begin
            rfc_d   = RFC_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (rfc_q == '0) begin
`ifdef REFRESH_CTRL_POSTPONE_EN
               if (pend_q != 4'd0) begin
                  state_d = ST_REF;
               end else begin
                  state_d = ST_IDLE;
                  end_d   = 1'b1;
               end
`else
               state_d = ST_IDLE;
               end_d   = 1'b1;
`endif
            end else begin
               rfc_d = rfc_q - RFC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      req_d  = (state_d != ST_IDLE);
      ref_d  = (state_d == ST_REF);
      busy_d = (state_d != ST_IDLE);
`ifdef REFRESH_CTRL_POSTPONE_EN
      urgent_d = (pend_d == PEND_MAX);
`else
      urgent_d = req_d;
`endif
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= CNT_LOAD;
         rfc_q    <= '0;
         pend_q   <= 4'd0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         ref_q    <= 1'b0;
         end_q    <= 1'b0;
         busy_q   <= 1'b0;
         urgent_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rfc_q    <= rfc_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         req_q    <= req_d;
         ref_q    <= ref_d;
         end_q    <= end_d;
         busy_q   <= busy_d;
         urgent_q <= urgent_d;
      end
   end

   assign rfc_req_o    = req_q;
   assign ref_cmd_o    = ref_q;
   assign rfc_end_o    = end_q;
   assign busy_o       = busy_q;
   assign rfc_urgent_o = urgent_q;
   assign pend_o       = pend_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_refresh_ctrl.sv
// Self-checking bench for refresh_ctrl: directed timeline checks plus randomized traffic against a cycle model.
module tb_refresh_ctrl;

   localparam int unsigned TREFI   = 20;
   localparam int unsigned TRFC    = 4;
   localparam int unsigned MAXPEND = 3;
`ifdef REFRESH_CTRL_POSTPONE_EN
   localparam bit POSTPONE = 1'b1;
   localparam int EMAX     = MAXPEND;
`else
   localparam bit POSTPONE = 1'b0;
   localparam int EMAX     = 1;
`endif

   logic       clock_i   = 1'b0;
   logic       reset_ni  = 1'b0;
   logic       enable_i  = 1'b0;
   logic       rfc_ack_i = 1'b0;
   logic       rfc_req_o;
   logic       rfc_end_o;
   logic       ref_cmd_o;
   logic       rfc_urgent_o;
   logic [3:0] pend_o;
   logic       busy_o;
   logic       err_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   refresh_ctrl #(.TREFI(TREFI), .TRFC(TRFC), .MAXPEND(MAXPEND)) dut (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .enable_i     (enable_i),
      .rfc_req_o    (rfc_req_o),
      .rfc_ack_i    (rfc_ack_i),
      .rfc_end_o    (rfc_end_o),
      .ref_cmd_o    (ref_cmd_o),
      .rfc_urgent_o (rfc_urgent_o),
      .pend_o       (pend_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   // Reference model: phase 0 idle, 1 asking for the bus, 2 strobing a refresh, 3 spacing gap
   int m_left  = TREFI - 1;
   int m_pend  = 0;
   int m_phase = 0;
   int m_gap   = 0;
   bit m_err   = 1'b0;
   bit m_end   = 1'b0;

   initial forever begin
      bit tick;
      bit issue;
      int old_pend;
      @(posedge clock_i or negedge reset_ni);
      if (!reset_ni) begin
         m_left  = TREFI - 1;
         m_pend  = 0;
         m_phase = 0;
         m_gap   = 0;
         m_err   = 1'b0;
         m_end   = 1'b0;
      end else begin
         tick     = enable_i && (m_left == 0);
         m_left   = (!enable_i || m_left == 0) ? TREFI - 1 : m_left - 1;
         issue    = (m_phase == 2);
         old_pend = m_pend;
         if (tick && !issue) begin
            if (m_pend == EMAX) m_err = 1'b1;
            else m_pend = m_pend + 1;
         end else if (issue && !tick) begin
            m_pend = m_pend - 1;
         end
         m_end = 1'b0;
         case (m_phase)
            0: if (old_pend != 0) m_phase = 1;
            1: if (rfc_ack_i) m_phase = 2;
            2: begin
               m_phase = 3;
               m_gap   = TRFC;
            end
            default: begin
               m_gap = m_gap - 1;
               if (m_gap == 0) begin
                  if (POSTPONE && old_pend != 0) begin
                     m_phase = 2;
                  end else begin
                     m_phase = 0;
                     m_end   = 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge clock_i);
      if (cmp_en) begin
         chk("m_req",    rfc_req_o,    m_phase != 0);
         chk("m_ref",    ref_cmd_o,    m_phase == 2);
         chk("m_busy",   busy_o,       m_phase != 0);
         chk("m_end",    rfc_end_o,    m_end);
         chk("m_pend",   pend_o,       m_pend);
         chk("m_err",    err_o,        m_err);
         chk("m_urgent", rfc_urgent_o, POSTPONE ? (m_pend == EMAX) : (m_phase != 0));
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},    rfc_req_o,    0);
      chk({tag, "_ref"},    ref_cmd_o,    0);
      chk({tag, "_end"},    rfc_end_o,    0);
      chk({tag, "_urgent"}, rfc_urgent_o, 0);
      chk({tag, "_pend"},   pend_o,       0);
      chk({tag, "_busy"},   busy_o,       0);
      chk({tag, "_err"},    err_o,        0);
   endtask

   initial begin
      int pct;
      repeat (3) @(posedge clock_i);
      #1;
      reset_ni = 1'b1;
      cmp_en   = 1'b1;
      repeat (3) step();
      chk_all_zero("reset");

      // First tick, request, single grant and sequence end
      enable_i = 1'b1;
      for (int k = 0; k < 30; k++) begin
         rfc_ack_i = (k == 22);
         chk("s1_pend", pend_o,    (k >= 20 && k < 24));
         chk("s1_req",  rfc_req_o, (k >= 21 && k < 28));
         chk("s1_ref",  ref_cmd_o, (k == 23));
         chk("s1_end",  rfc_end_o, (k == 28));
         chk("s1_busy", busy_o,    (k >= 21 && k < 28));
         if (k == 20) chk("model_pend20", m_pend, 1);
         if (k == 23) chk("model_ref23", m_phase, 2);
         step();
      end

`ifdef REFRESH_CTRL_POSTPONE_EN
      // Backlog build-up, overflow, and a tick coinciding with an issue
      for (int k = 30; k <= 240; k++) begin
         rfc_ack_i = (k == 82 || k == 161 || k == 218);
         if (k == 80) begin
            chk("s3_pend3", pend_o, 3);
            chk("s3_urgent", rfc_urgent_o, 1);
         end
         if (k >= 80 && k <= 98) begin
            chk("s3_ref", ref_cmd_o, (k == 83 || k == 88 || k == 93));
            chk("s3_end", rfc_end_o, (k == 98));
         end
         if (k == 98) chk("s3_pend0", pend_o, 0);
         if (k == 160) begin
            chk("s4_err", err_o, 1);
            chk("s4_pend3", pend_o, 3);
         end
         if (k >= 161 && k <= 177) begin
            chk("s4_ref", ref_cmd_o, (k == 162 || k == 167 || k == 172));
            chk("s4_end", rfc_end_o, (k == 177));
         end
         if (k == 178) begin
            chk("s4_err_sticky", err_o, 1);
            chk("s4_pend0", pend_o, 0);
         end
         if (k >= 218 && k <= 234) begin
            chk("s5_ref", ref_cmd_o, (k == 219 || k == 224 || k == 229));
            chk("s5_end", rfc_end_o, (k == 234));
         end
         if (k == 220) chk("s5_pend2", pend_o, 2);
         step();
      end
`endif

      // Asynchronous reset in the middle of the tRFC gap
      rfc_ack_i = 1'b0;
      reset_ni  = 1'b0;
      step();
      step();
      enable_i = 1'b1;
      reset_ni = 1'b1;
      for (int k = 0; k < 25; k++) begin
         rfc_ack_i = (k == 22);
         step();
      end
      rfc_ack_i = 1'b0;
      chk("s6_busy_wait", busy_o, 1);
      #3;
      reset_ni = 1'b0;
      #1;
      chk_all_zero("s6_async");
      #2;
      reset_ni = 1'b1;
      for (int j = 1; j <= 21; j++) begin
         step();
         chk("s6_first_tick", pend_o, (j >= 20));
      end

      // Randomized traffic with varying grant pressure and occasional resets
      for (int c = 0; c < 4000; c++) begin
         case ((c / 300) % 3)
            0:       pct = 3;
            1:       pct = 25;
            default: pct = 90;
         endcase
         enable_i  = ((c % 500) >= 400 && (c % 500) < 430) ? 1'b0 : ($urandom_range(0, 39) != 0);
         rfc_ack_i = ($urandom_range(0, 99) < pct);
         if ($urandom_range(0, 1499) == 0) begin
            #3;
            reset_ni = 1'b0;
            step();
            #2;
            reset_ni = 1'b1;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
